rv32i_exec_core: RTL and testbench

Combined execute/memory slice of the single-cycle RV32I core: the main instruction decoder (control), the integer ALU and the 4 KiB byte-addressable data memory. It takes a fetched instruction, register operands and the sign-extended immediate, and produces all datapath control strobes, the ALU result and flags, and load data. The register file, sign-extender, PC and load/store lane decoder are outside this block.

---
 rtl/rv32i_exec_core.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_rv32i_exec_core.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_exec_core.sv
// ---------------------------------------------------------------------------
// rv32i_exec_core
//   Execute/memory slice of a single-cycle RV32I core. It holds the main
//   instruction decoder, the integer ALU and a 4 KiB byte-lane data memory.
//
//   Optional feature macro: RV32I_DEBUG_PORT_EN
//     defined   -> debug_data_o = mem[debug_addr_i[11:2]] (asynchronous read)
//     undefined -> debug_data_o tied to 0, no read logic
//
//   Ports
//     clk_i, rst_i            clock; synchronous active-low reset (0 = reset)
//     instr_i                 current instruction
//     rs1_i, rs2_i, imm_i     register operands, sign-extended immediate
//     st_data_i/st_byte_enb_i lane-aligned store data and byte lanes
//     ext_sel_i, ext_w_*_i    init write port; owns the memory when ext_sel_i=1
//     debug_addr_i/debug_data_o  verification word read
//     branch_o .. reg_write_o control strobes
//     imm_src_o, alu_ctrl_o, wrt_back_src_o, second_add_src_o  control codes
//     alu_result_o, alu_zero_o, alu_last_bit_o  ALU result and flags
//     mem_rdata_o             load word (0 when mem_read_o=0)
// ---------------------------------------------------------------------------
module rv32i_exec_core #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] st_data_i,
    input  logic [3:0]  st_byte_enb_i,
    input  logic        ext_sel_i,
    input  logic [11:0] ext_w_addr_i,
    input  logic [31:0] ext_w_dat_i,
    input  logic        ext_w_enb_i,
    input  logic [3:0]  ext_w_byte_enb_i,
    input  logic [11:0] debug_addr_i,
    output logic [31:0] debug_data_o,
    output logic        branch_o,
    output logic        mem_read_o,
    output logic        mem_2_reg_o,
    output logic        mem_write_o,
    output logic        alu_src_o,
    output logic        reg_write_o,
    output logic [2:0]  imm_src_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [1:0]  wrt_back_src_o,
    output logic [1:0]  second_add_src_o,
    output logic [31:0] alu_result_o,
    output logic        alu_zero_o,
    output logic        alu_last_bit_o,
    output logic [31:0] mem_rdata_o
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_U   = 2'b11;

    localparam logic [1:0] SA_NONE  = 2'b00;
    localparam logic [1:0] SA_LUI   = 2'b01;
    localparam logic [1:0] SA_AUIPC = 2'b10;
    localparam logic [1:0] SA_JALR  = 2'b11;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7b5;

    assign opcode  = instr_i[6:0];
    assign func3   = instr_i[14:12];
    assign func7b5 = instr_i[30];

    // Shared R/I arithmetic mapping. Only the register form may pick SUB;
    // in the immediate form bit 30 belongs to the immediate except for SRAI.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic b30,
                                            input logic reg_form);
        case (f3)
            3'b000:  arith_op = (reg_form && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Main decoder. While reset is asserted every output stays at NOP.
    // ---------------------------------------------------------------------
    logic is_jump;
    logic is_branch;

    always_comb begin
        mem_read_o       = 1'b0;
        mem_2_reg_o      = 1'b0;
        mem_write_o      = 1'b0;
        alu_src_o        = 1'b0;
        reg_write_o      = 1'b0;
        imm_src_o        = IMM_I;
        alu_ctrl_o       = ALU_ADD;
        wrt_back_src_o   = WB_MEM;
        second_add_src_o = SA_NONE;
        is_jump          = 1'b0;
        is_branch        = 1'b0;
        if (rst_i) begin
            case (opcode)
                OP_R: begin
                    reg_write_o    = 1'b1;
                    wrt_back_src_o = WB_ALU;
                    alu_ctrl_o     = arith_op(func3, func7b5, 1'b1);
                end
                OP_I: begin
                    reg_write_o    = 1'b1;
                    alu_src_o      = 1'b1;
                    wrt_back_src_o = WB_ALU;
                    alu_ctrl_o     = arith_op(func3, func7b5, 1'b0);
                end
                OP_LD: begin
                    mem_read_o  = 1'b1;
                    mem_2_reg_o = 1'b1;
                    reg_write_o = 1'b1;
                    alu_src_o   = 1'b1;
                end
                OP_ST: begin
                    mem_write_o = 1'b1;
                    alu_src_o   = 1'b1;
                    imm_src_o   = IMM_S;
                end
                OP_BR: begin
                    is_branch = 1'b1;
                    imm_src_o = IMM_B;
                    case (func3)
                        3'b000, 3'b001: alu_ctrl_o = ALU_SUB;
                        3'b100, 3'b101: alu_ctrl_o = ALU_SLT;
                        3'b110, 3'b111: alu_ctrl_o = ALU_SLTU;
                        default:        alu_ctrl_o = ALU_ADD;
                    endcase
                end
                OP_JAL: begin
                    is_jump        = 1'b1;
                    reg_write_o    = 1'b1;
                    wrt_back_src_o = WB_PC4;
                    imm_src_o      = IMM_J;
                end
                OP_JALR: begin
                    is_jump          = 1'b1;
                    reg_write_o      = 1'b1;
                    wrt_back_src_o   = WB_PC4;
                    second_add_src_o = SA_JALR;
                end
                OP_LUI: begin
                    reg_write_o      = 1'b1;
                    imm_src_o        = IMM_U;
                    wrt_back_src_o   = WB_U;
                    second_add_src_o = SA_LUI;
                end
                OP_AUIPC: begin
                    reg_write_o      = 1'b1;
                    imm_src_o        = IMM_U;
                    wrt_back_src_o   = WB_U;
                    second_add_src_o = SA_AUIPC;
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // ALU
    // ---------------------------------------------------------------------
    logic [31:0] alu_b;
    logic [4:0]  shamt;

    always_comb begin
        alu_b = alu_src_o ? imm_i : rs2_i;
        shamt = alu_b[4:0];
        case (alu_ctrl_o)
            ALU_ADD:  alu_result_o = rs1_i + alu_b;
            ALU_SUB:  alu_result_o = rs1_i - alu_b;
            ALU_AND:  alu_result_o = rs1_i & alu_b;
            ALU_OR:   alu_result_o = rs1_i | alu_b;
            ALU_XOR:  alu_result_o = rs1_i ^ alu_b;
            ALU_SLL:  alu_result_o = rs1_i << shamt;
            ALU_SRL:  alu_result_o = rs1_i >> shamt;
            ALU_SRA:  alu_result_o = $unsigned($signed(rs1_i) >>> shamt);
            ALU_SLT:  alu_result_o = {31'd0, $signed(rs1_i) < $signed(alu_b)};
            ALU_SLTU: alu_result_o = {31'd0, rs1_i < alu_b};
            default:  alu_result_o = 32'd0;
        endcase
    end

    assign alu_zero_o     = (alu_result_o == 32'd0);
    assign alu_last_bit_o = alu_result_o[0];

    // Branch resolution sits after the ALU: BEQ/BNE look at the zero flag of
    // the SUB, the ordered compares look at bit 0 of SLT/SLTU.
    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        if (is_branch) begin
            case (func3)
                3'b000:         br_taken = alu_zero_o;
                3'b001:         br_taken = ~alu_zero_o;
                3'b100, 3'b110: br_taken = alu_last_bit_o;
                3'b101, 3'b111: br_taken = ~alu_last_bit_o;
                default:        br_taken = 1'b0;
            endcase
        end
    end

    assign branch_o = is_jump | br_taken;

    // ---------------------------------------------------------------------
    // Data memory: one write port (muxed between init port and core store),
    // asynchronous reads. Contents are not cleared by reset.
    // ---------------------------------------------------------------------
    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_lanes;
    logic          wr_en;

    always_comb begin
        if (ext_sel_i) begin
            wr_idx   = ext_w_addr_i[AW+1:2];
            wr_data  = ext_w_dat_i;
            wr_en    = ext_w_enb_i;
            wr_lanes = ext_w_byte_enb_i;
        end else begin
            wr_idx   = alu_result_o[AW+1:2];
            wr_data  = st_data_i;
            wr_en    = mem_write_o;
            wr_lanes = st_byte_enb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_lanes[l]) begin
                    mem[wr_idx][l*8 +: 8] <= wr_data[l*8 +: 8];
                end
            end
        end
    end

    // Low two address bits are ignored: loads always return the whole word.
    assign rd_idx      = alu_result_o[AW+1:2];
    assign mem_rdata_o = mem_read_o ? mem[rd_idx] : 32'd0;

`ifdef RV32I_DEBUG_PORT_EN
    assign debug_data_o = mem[debug_addr_i[AW+1:2]];
`else
    assign debug_data_o = 32'd0;
`endif

    logic unused_bits;
    assign unused_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7],
                           alu_result_o[31:AW+2], alu_result_o[1:0],
                           ext_w_addr_i[1:0], debug_addr_i};

endmodule

// File: tb/tb_rv32i_exec_core.sv
// ---------------------------------------------------------------------------
// Self-checking bench for rv32i_exec_core: directed scenarios followed by a
// randomized run against a word-array memory model and a decode/ALU model
// computed straight from instruction semantics.
// ---------------------------------------------------------------------------
module tb_rv32i_exec_core;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       br, mr, m2r, mw, asrc, rw;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [1:0] wb, sa;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, rs1, rs2, imm, st_data;
    logic [3:0]  st_byte_enb;
    logic        ext_sel;
    logic [11:0] ext_w_addr;
    logic [31:0] ext_w_dat;
    logic        ext_w_enb;
    logic [3:0]  ext_w_byte_enb;
    logic [11:0] debug_addr;
    logic [31:0] debug_data;
    logic        branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl;
    logic [1:0]  wrt_back_src, second_add_src;
    logic [31:0] alu_result;
    logic        alu_zero, alu_last_bit;
    logic [31:0] mem_rdata;

    logic [31:0] mdl [1024];
    int passed = 0;
    int total  = 0;
    ctl_t dut_ctl;

    always #5 clk = ~clk;

    rv32i_exec_core #(.MEM_WORDS(1024)) dut (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .rs1_i(rs1), .rs2_i(rs2),
        .imm_i(imm), .st_data_i(st_data), .st_byte_enb_i(st_byte_enb),
        .ext_sel_i(ext_sel), .ext_w_addr_i(ext_w_addr), .ext_w_dat_i(ext_w_dat),
        .ext_w_enb_i(ext_w_enb), .ext_w_byte_enb_i(ext_w_byte_enb),
        .debug_addr_i(debug_addr), .debug_data_o(debug_data),
        .branch_o(branch), .mem_read_o(mem_read), .mem_2_reg_o(mem_2_reg),
        .mem_write_o(mem_write), .alu_src_o(alu_src), .reg_write_o(reg_write),
        .imm_src_o(imm_src), .alu_ctrl_o(alu_ctrl), .wrt_back_src_o(wrt_back_src),
        .second_add_src_o(second_add_src), .alu_result_o(alu_result),
        .alu_zero_o(alu_zero), .alu_last_bit_o(alu_last_bit), .mem_rdata_o(mem_rdata)
    );

    assign dut_ctl = {branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write,
                      imm_src, alu_ctrl, wrt_back_src, second_add_src};

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7);
        mk = {f7, 10'h000, f3, 5'h00, opc};
    endfunction

    // ---- reference model -------------------------------------------------
    function automatic logic [3:0] ref_arith(input logic [2:0] f3, input logic alt,
                                             input logic reg_form);
        case (f3)
            3'b000:  ref_arith = (reg_form && alt) ? 4'd1 : 4'd0;
            3'b001:  ref_arith = 4'd5;
            3'b010:  ref_arith = 4'd8;
            3'b011:  ref_arith = 4'd9;
            3'b100:  ref_arith = 4'd4;
            3'b101:  ref_arith = alt ? 4'd7 : 4'd6;
            3'b110:  ref_arith = 4'd3;
            default: ref_arith = 4'd2;
        endcase
    endfunction

    function automatic ctl_t ref_ctl(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b);
        ctl_t c;
        logic [2:0] f3;
        c  = '0;
        f3 = ins[14:12];
        case (ins[6:0])
            OP_R:    begin c.rw = 1; c.wb = 2'b01; c.alu = ref_arith(f3, ins[30], 1'b1); end
            OP_I:    begin c.rw = 1; c.asrc = 1; c.wb = 2'b01;
                           c.alu = ref_arith(f3, ins[30], 1'b0); end
            OP_LD:   begin c.mr = 1; c.m2r = 1; c.rw = 1; c.asrc = 1; end
            OP_ST:   begin c.mw = 1; c.asrc = 1; c.imm = 3'b001; end
            OP_BR: begin
                c.imm = 3'b010;
                case (f3)
                    3'b000: begin c.alu = 4'd1; c.br = (a == b); end
                    3'b001: begin c.alu = 4'd1; c.br = (a != b); end
                    3'b100: begin c.alu = 4'd8; c.br = ($signed(a) <  $signed(b)); end
                    3'b101: begin c.alu = 4'd8; c.br = ($signed(a) >= $signed(b)); end
                    3'b110: begin c.alu = 4'd9; c.br = (a <  b); end
                    3'b111: begin c.alu = 4'd9; c.br = (a >= b); end
                    default: ;
                endcase
            end
            OP_JAL:   begin c.br = 1; c.rw = 1; c.wb = 2'b10; c.imm = 3'b100; end
            OP_JALR:  begin c.br = 1; c.rw = 1; c.wb = 2'b10; c.sa = 2'b11; end
            OP_LUI:   begin c.rw = 1; c.imm = 3'b011; c.wb = 2'b11; c.sa = 2'b01; end
            OP_AUIPC: begin c.rw = 1; c.imm = 3'b011; c.wb = 2'b11; c.sa = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0: alu_ref = a + b;
            4'd1: alu_ref = a - b;
            4'd2: alu_ref = a & b;
            4'd3: alu_ref = a | b;
            4'd4: alu_ref = a ^ b;
            4'd5: alu_ref = a << b[4:0];
            4'd6: alu_ref = a >> b[4:0];
            4'd7: alu_ref = 32'($signed(a) >>> b[4:0]);
            4'd8: alu_ref = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: alu_ref = (a < b) ? 32'd1 : 32'd0;
            default: alu_ref = 32'd0;
        endcase
    endfunction

    task automatic mdl_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] l);
        for (int i = 0; i < 4; i++)
            if (l[i]) mdl[a[11:2]][i*8 +: 8] = d[i*8 +: 8];
    endtask

    task automatic ext_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] l);
        @(negedge clk);
        ext_sel = 1; ext_w_addr = a; ext_w_dat = d; ext_w_byte_enb = l; ext_w_enb = 1;
        @(posedge clk);
        #1;
        if (rst) mdl_write(a, d, l);
        ext_w_enb = 0; ext_sel = 0;
    endtask

    // ---- scenarios -------------------------------------------------------
    task automatic test_reset();
        rst = 0;
        @(negedge clk);
        instr = mk(OP_ST, 3'b010, 7'h00); rs1 = 32'h4; imm = 0; st_byte_enb = 4'hF;
        #1;
        total++; if (dut_ctl !== ctl_t'(0)) $display("FAIL reset_store_ctl: got %h want %h", dut_ctl, ctl_t'(0)); else passed++;
        instr = mk(OP_LD, 3'b010, 7'h00);
        #1;
        total++; if (dut_ctl !== ctl_t'(0)) $display("FAIL reset_load_ctl: got %h want %h", dut_ctl, ctl_t'(0)); else passed++;
        total++; if (mem_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", mem_rdata); else passed++;
    endtask

    task automatic init_mem();
        rst = 1;
        for (int i = 0; i < 1024; i++) ext_write(12'(i * 4), 32'h0, 4'hF);
    endtask

    task automatic test_init_port();
        ext_write(12'h000, 32'h0000_00AB, 4'hF);
        @(negedge clk);
        instr = mk(OP_LD, 3'b010, 7'h00); rs1 = 0; imm = 0; debug_addr = 12'h000;
        #1;
        total++; if (mem_rdata !== 32'h0000_00AB) $display("FAIL init_load: got %h want 000000ab", mem_rdata); else passed++;
`ifdef RV32I_DEBUG_PORT_EN
        total++; if (debug_data !== 32'h0000_00AB) $display("FAIL init_debug: got %h want 000000ab", debug_data); else passed++;
`else
        total++; if (debug_data !== 32'h0) $display("FAIL debug_tied: got %h want 0", debug_data); else passed++;
`endif
    endtask

    task automatic test_store_lanes();
        @(negedge clk);
        ext_sel = 0; instr = mk(OP_ST, 3'b000, 7'h00); rs1 = 32'h1; imm = 0;
        st_data = 32'h0000_CD00; st_byte_enb = 4'b0010;
        #1;
        total++; if (alu_result !== 32'h1) $display("FAIL sb_addr: got %h want 1", alu_result); else passed++;
        total++; if (mem_write !== 1'b1) $display("FAIL sb_mem_write: got %b want 1", mem_write); else passed++;
        @(posedge clk); #1;
        mdl_write(12'h001, 32'h0000_CD00, 4'b0010);
        instr = mk(OP_LD, 3'b010, 7'h00); rs1 = 0;
        #1;
        total++; if (mem_rdata !== 32'h0000_CDAB) $display("FAIL sb_merge: got %h want 0000cdab", mem_rdata); else passed++;
        @(negedge clk);
        instr = mk(OP_ST, 3'b010, 7'h00); rs1 = 32'hC; st_data = 32'hFFFF_FFEF; st_byte_enb = 4'b0001;
        @(posedge clk); #1;
        mdl_write(12'h00C, 32'hFFFF_FFEF, 4'b0001);
        instr = mk(OP_LD, 3'b010, 7'h00);
        #1;
        total++; if (mem_rdata !== 32'h0000_00EF) $display("FAIL lane_mask: got %h want 000000ef", mem_rdata); else passed++;
    endtask

    task automatic test_load();
        @(negedge clk);
        instr = mk(OP_LD, 3'b010, 7'h00); rs1 = 0; imm = 0;
        #1;
        total++; if (mem_read !== 1'b1) $display("FAIL lw_mem_read: got %b want 1", mem_read); else passed++;
        total++; if (wrt_back_src !== 2'b00) $display("FAIL lw_wb: got %b want 00", wrt_back_src); else passed++;
        total++; if (mem_rdata !== 32'h0000_CDAB) $display("FAIL lw_data: got %h want 0000cdab", mem_rdata); else passed++;
        rs1 = 32'h0000_1003; // wraps to byte 0x003 -> word 0
        #1;
        total++; if (mem_rdata !== 32'h0000_CDAB) $display("FAIL lw_wrap: got %h want 0000cdab", mem_rdata); else passed++;
    endtask

    task automatic test_alu_directed();
        @(negedge clk);
        instr = mk(OP_R, 3'b000, 7'h20); rs1 = 5; rs2 = 5;
        #1;
        total++; if (alu_result !== 32'h0 || alu_zero !== 1'b1) $display("FAIL sub_zero: got %h/%b want 0/1", alu_result, alu_zero); else passed++;
        instr = mk(OP_BR, 3'b000, 7'h00);
        #1;
        total++; if (branch !== 1'b1) $display("FAIL beq_taken: got %b want 1", branch); else passed++;
        instr = mk(OP_R, 3'b010, 7'h00); rs1 = 32'hFFFF_FFFF; rs2 = 1;
        #1;
        total++; if (alu_result !== 32'h1 || alu_last_bit !== 1'b1) $display("FAIL slt_neg: got %h/%b want 1/1", alu_result, alu_last_bit); else passed++;
        instr = mk(OP_R, 3'b101, 7'h20); rs1 = 32'h8000_0000; rs2 = 4;
        #1;
        total++; if (alu_result !== 32'hF800_0000) $display("FAIL sra: got %h want f8000000", alu_result); else passed++;
        instr = mk(OP_R, 3'b101, 7'h00);
        #1;
        total++; if (alu_result !== 32'h0800_0000) $display("FAIL srl: got %h want 08000000", alu_result); else passed++;
        instr = mk(OP_BR, 3'b111, 7'h00); rs1 = 1; rs2 = 2;
        #1;
        total++; if (branch !== 1'b0) $display("FAIL bgeu_not_taken: got %b want 0", branch); else passed++;
    endtask

    task automatic test_reset_blocks_writes();
        @(negedge clk);
        rst = 0; instr = mk(OP_ST, 3'b010, 7'h00); rs1 = 32'hC; imm = 0;
        st_data = 32'h1234_5678; st_byte_enb = 4'hF;
        #1;
        total++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write: got %b want 0", mem_write); else passed++;
        @(posedge clk); #1;
        ext_sel = 1; ext_w_enb = 1; ext_w_addr = 12'h000; ext_w_dat = 32'hFFFF_FFFF; ext_w_byte_enb = 4'hF;
        @(posedge clk); #1;
        ext_sel = 0; ext_w_enb = 0; rst = 1;
        instr = mk(OP_LD, 3'b010, 7'h00); rs1 = 32'hC;
        #1;
        total++; if (mem_rdata !== 32'h0000_00EF) $display("FAIL rst_no_store: got %h want 000000ef", mem_rdata); else passed++;
        rs1 = 0;
        #1;
        total++; if (mem_rdata !== 32'h0000_CDAB) $display("FAIL rst_no_ext: got %h want 0000cdab", mem_rdata); else passed++;
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        instr = mk(OP_LD, 3'b010, 7'h00); rs1 = 32'h10; imm = 0;
        ext_sel = 1; ext_w_enb = 1; ext_w_addr = 12'h010; ext_w_dat = 32'hA5A5_5A5A; ext_w_byte_enb = 4'hF;
        #1;
        total++; if (mem_rdata !== mdl[4]) $display("FAIL same_cycle_old: got %h want %h", mem_rdata, mdl[4]); else passed++;
        @(posedge clk); #1;
        ext_w_enb = 0; ext_sel = 0;
        mdl_write(12'h010, 32'hA5A5_5A5A, 4'hF);
        #1;
        total++; if (mem_rdata !== 32'hA5A5_5A5A) $display("FAIL same_cycle_new: got %h want a5a55a5a", mem_rdata); else passed++;
    endtask

    task automatic test_random(input int n);
        logic [6:0]  ops [11];
        logic [31:0] ins, b, er, exp_rd;
        ctl_t        ec;
        logic        use_ext;
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
                7'b0001111, 7'b1111111};
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 10)];
            if (ins[6:0] == OP_R || ins[6:0] == OP_I)
                ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            instr = ins;
            rs1 = $urandom;
            case ($urandom_range(0, 3))
                0:       rs2 = rs1;
                1:       rs2 = rs1 + 32'd1;
                default: rs2 = $urandom;
            endcase
            imm = $urandom; st_data = $urandom; st_byte_enb = 4'($urandom);
            debug_addr = 12'($urandom);
            use_ext = ($urandom_range(0, 3) == 0);
            ext_sel = use_ext; ext_w_enb = 1'($urandom); ext_w_addr = 12'($urandom);
            ext_w_dat = $urandom; ext_w_byte_enb = 4'($urandom);
            #1;
            ec = ref_ctl(ins, rs1, rs2);
            b  = ec.asrc ? imm : rs2;
            er = alu_ref(ec.alu, rs1, b);
            exp_rd = ec.mr ? mdl[er[11:2]] : 32'h0;
            total++; if (dut_ctl !== ec) $display("FAIL rnd_ctl[%0d] ins=%h: got %h want %h", k, ins, dut_ctl, ec); else passed++;
            total++; if (alu_result !== er) $display("FAIL rnd_alu[%0d] ins=%h: got %h want %h", k, ins, alu_result, er); else passed++;
            total++; if (alu_zero !== (er == 0) || alu_last_bit !== er[0]) $display("FAIL rnd_flags[%0d]: got %b%b want %b%b", k, alu_zero, alu_last_bit, (er == 0), er[0]); else passed++;
            total++; if (mem_rdata !== exp_rd) $display("FAIL rnd_rdata[%0d]: got %h want %h", k, mem_rdata, exp_rd); else passed++;
`ifdef RV32I_DEBUG_PORT_EN
            total++; if (debug_data !== mdl[debug_addr[11:2]]) $display("FAIL rnd_debug[%0d]: got %h want %h", k, debug_data, mdl[debug_addr[11:2]]); else passed++;
`else
            total++; if (debug_data !== 32'h0) $display("FAIL rnd_debug_tied[%0d]: got %h want 0", k, debug_data); else passed++;
`endif
            @(posedge clk); #1;
            if (use_ext) begin
                if (ext_w_enb) mdl_write(ext_w_addr, ext_w_dat, ext_w_byte_enb);
            end else if (ec.mw) begin
                mdl_write(er[11:0], st_data, st_byte_enb);
            end
            ext_sel = 0; ext_w_enb = 0;
        end
    endtask

    initial begin
        instr = 0; rs1 = 0; rs2 = 0; imm = 0; st_data = 0; st_byte_enb = 0;
        ext_sel = 0; ext_w_addr = 0; ext_w_dat = 0; ext_w_enb = 0; ext_w_byte_enb = 0;
        debug_addr = 0; rst = 0;
        for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
        test_reset();
        init_mem();
        test_init_port();
        test_store_lanes();
        test_load();
        test_alu_directed();
        test_reset_blocks_writes();
        test_same_cycle();
        test_random(400);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
